// File: rtl/fpr_cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fpr_cdb_arbiter_if
// Description : Bundle between the FP execution units and the FPR CDB
//               arbiter. It carries the per-unit request side (valid, ready,
//               ROB tag, 32-bit result) and the registered broadcast side
//               (fpr_cdb_valid / fpr_cdb_tag / fpr_cdb_data) that the
//               reservation stations and the ROB snoop.
//               Modports:
//                 slave  - the arbiter: takes requests, drives ready and
//                          the broadcast.
//                 master - requesters / snoopers: drive requests, observe
//                          ready and the broadcast.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpr_cdb_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int ROB_WIDTH = 6
);
    logic [N_REQ-1:0]                  req_valid;
    logic [N_REQ-1:0]                  req_ready;
    logic [N_REQ-1:0][ROB_WIDTH-1:0]   req_tag;
    logic [N_REQ-1:0][31:0]            req_data;

    logic                              fpr_cdb_valid;
    logic [ROB_WIDTH-1:0]              fpr_cdb_tag;
    logic [31:0]                       fpr_cdb_data;

    modport slave (
        input  req_valid,
        input  req_tag,
        input  req_data,
        output req_ready,
        output fpr_cdb_valid,
        output fpr_cdb_tag,
        output fpr_cdb_data
    );

    modport master (
        output req_valid,
        output req_tag,
        output req_data,
        input  req_ready,
        input  fpr_cdb_valid,
        input  fpr_cdb_tag,
        input  fpr_cdb_data
    );
endinterface
`default_nettype wire

// File: rtl/fpr_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpr_cdb_arbiter
// Description : Round-robin arbiter for the floating-point common data bus.
//               Each cycle at most one requesting FP unit (0 fadd, 1 fmul,
//               2 fdiv, 3 fsqrt) is granted; the winner's tag and result are
//               registered onto the bus for exactly one cycle and the
//               priority pointer moves to the index after the winner.
// Ports       : clk   - single clock, rising edge
//               reset - asynchronous, active-low reset
//               bus   - request / broadcast bundle (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module fpr_cdb_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ROB_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    fpr_cdb_arbiter_if.slave     bus
);

    localparam int                   c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_PTR_W:0]     c_N_EXT = (c_PTR_W + 1)'(N_REQ);
    localparam logic [c_PTR_W-1:0]   c_LAST  = c_PTR_W'(N_REQ - 1);

    logic [c_PTR_W-1:0]   r_ptr;
    logic                 r_cdb_valid;
    logic [ROB_WIDTH-1:0] r_cdb_tag;
    logic [31:0]          r_cdb_data;

    logic                 w_found;
    logic [c_PTR_W-1:0]   w_idx;
    logic [c_PTR_W:0]     w_sum;
    logic [c_PTR_W-1:0]   w_next_ptr;
    logic                 w_handshake;

    // Scan priority order ptr, ptr+1, ... (mod N_REQ); first valid wins.
    // Only req_valid and ptr feed this search, so ready never depends on
    // tag or data.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (c_PTR_W + 1)'(k);
            if (w_sum >= c_N_EXT) begin
                w_sum = w_sum - c_N_EXT;
            end
            if (!w_found && bus.req_valid[w_sum[c_PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_sum[c_PTR_W-1:0];
            end
        end
    end

    // Ready is suppressed while reset is held low, independent of the clock.
    always_comb begin
        bus.req_ready = '0;
        if (reset && w_found) begin
            bus.req_ready[w_idx] = 1'b1;
        end
    end

    assign w_handshake = |(bus.req_valid & bus.req_ready);
    assign w_next_ptr  = (w_idx == c_LAST) ? '0 : w_idx + 1'b1;

    // Tag and data hold their last broadcast when idle; only valid drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr       <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
        end else if (w_handshake) begin
            r_ptr       <= w_next_ptr;
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= bus.req_tag[w_idx];
            r_cdb_data  <= bus.req_data[w_idx];
        end else begin
            r_cdb_valid <= 1'b0;
        end
    end

    assign bus.fpr_cdb_valid = r_cdb_valid;
    assign bus.fpr_cdb_tag   = r_cdb_tag;
    assign bus.fpr_cdb_data  = r_cdb_data;

endmodule
`default_nettype wire

// File: tb/tb_fpr_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpr_cdb_arbiter
// Description : Self-checking bench for fpr_cdb_arbiter. A reference model
//               tracks the round-robin pointer, predicts req_ready, and
//               pushes the granted tag/data onto a scoreboard queue that is
//               popped when the broadcast appears on the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpr_cdb_arbiter;

    localparam int N         = 4;
    localparam int RW        = 6;

    logic clk;
    logic reset;

    fpr_cdb_arbiter_if #(.N_REQ(N), .ROB_WIDTH(RW)) bus ();

    fpr_cdb_arbiter #(.N_REQ(N), .ROB_WIDTH(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                 errors = 0;
    int                 checks = 0;
    int                 m_ptr  = 0;
    int                 m_last_g = -1;
    logic [RW-1:0]      m_tag  = '0;
    logic [31:0]        m_data = '0;
    logic [RW+31:0]     sb[$];
    int                 wait_cnt[N];
    int                 next_tag = 20;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference arbitration: first valid index in order ptr, ptr+1, ... mod N.
    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One clock: check ready after inputs settle, predict the handshake,
    // then check the broadcast just after the rising edge. Ends on negedge.
    task automatic cycle();
        int              g;
        logic [N-1:0]    exp_ready;
        logic [RW+31:0]  e;
        #1;
        g = reset ? model_grant(bus.req_valid, m_ptr) : -1;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("ready", 64'(bus.req_ready), 64'(exp_ready));
        if (g >= 0) begin
            sb.push_back({bus.req_tag[g], bus.req_data[g]});
            m_ptr = (g + 1) % N;
        end
        m_last_g = g;
        @(posedge clk);
        #1;
        chk("cdb_valid", 64'(bus.fpr_cdb_valid), 64'(g >= 0));
        if (bus.fpr_cdb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_broadcast", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                m_tag  = e[RW+31:32];
                m_data = e[31:0];
                chk("cdb_tag",  64'(bus.fpr_cdb_tag),  64'(m_tag));
                chk("cdb_data", 64'(bus.fpr_cdb_data), 64'(m_data));
            end
        end else begin
            sb.delete();
            chk("hold_tag",  64'(bus.fpr_cdb_tag),  64'(m_tag));
            chk("hold_data", 64'(bus.fpr_cdb_data), 64'(m_data));
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [RW-1:0] t, input logic [31:0] d);
        bus.req_valid[i] = 1'b1;
        bus.req_tag[i]   = t;
        bus.req_data[i]  = d;
    endtask

    task automatic drop_granted();
        if (m_last_g >= 0) bus.req_valid[m_last_g] = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_data  = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;

        // Reset state: no grant and a cleared bus even with a request pending.
        @(negedge clk);
        set_req(2, 6'd9, 32'hDEAD_0002);
        cycle();
        cycle();
        bus.req_valid = '0;
        reset = 1'b1;

        // Round-robin: all four request continuously from ptr=0 for 5 grants.
        for (int i = 0; i < N; i++) set_req(i, RW'(10 + i), 32'h4000_0000 + 32'(i));
        for (int k = 0; k < 5; k++) begin
            cycle();
            set_req(m_last_g, RW'(next_tag), $urandom());
            next_tag++;
        end
        bus.req_valid = '0;
        cycle();

        // Wrap-around and skip: reach ptr=3, then 0101 -> 0, then 2.
        set_req(2, 6'd33, 32'h1111_2222);
        cycle();
        drop_granted();
        set_req(0, 6'd34, 32'h3333_4444);
        set_req(2, 6'd35, 32'h5555_6666);
        cycle();
        drop_granted();
        cycle();
        drop_granted();
        cycle();

        // Single request to unit 1, then idle for 3 cycles with data held.
        set_req(1, 6'd5, 32'h3F80_0000);
        cycle();
        drop_granted();
        for (int k = 0; k < 3; k++) cycle();
        // ptr=2 with 0011 pending -> index 0 first, then index 1.
        set_req(0, 6'd40, 32'hAAAA_0000);
        set_req(1, 6'd41, 32'hBBBB_1111);
        cycle();
        drop_granted();
        cycle();
        drop_granted();

        // Reset mid-broadcast: bus must clear at once, ready must drop.
        set_req(0, 6'd42, 32'hCAFE_F00D);
        cycle();
        drop_granted();
        set_req(1, 6'd43, 32'h0BAD_BEEF);
        reset = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.fpr_cdb_valid), 64'(0));
        chk("rst_tag",   64'(bus.fpr_cdb_tag),   64'(0));
        chk("rst_data",  64'(bus.fpr_cdb_data),  64'(0));
        chk("rst_ready", 64'(bus.req_ready),     64'(0));
        m_ptr  = 0;
        m_tag  = '0;
        m_data = '0;
        sb.delete();
        @(negedge clk);
        cycle();
        reset = 1'b1;
        // Release with 0010 -> grant 1, ptr=2; then 0110 must pick index 2.
        cycle();
        set_req(1, 6'd44, 32'h1234_5678);
        set_req(2, 6'd45, 32'h9ABC_DEF0);
        cycle();
        drop_granted();
        cycle();
        drop_granted();
        cycle();

        // Random stress: requests held until granted, fairness within N cycles.
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] !== 1'b1 && $urandom_range(0, 1) == 1) begin
                    set_req(i, RW'(next_tag), $urandom());
                    next_tag++;
                end
                if (bus.req_valid[i] === 1'b1) wait_cnt[i]++;
            end
            cycle();
            if (m_last_g >= 0) begin
                chk("fairness", 64'(wait_cnt[m_last_g] <= N), 64'(1));
                wait_cnt[m_last_g] = 0;
                drop_granted();
            end
        end
        bus.req_valid = '0;
        cycle();
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
